spike_rate_decoder: RTL and testbench
=====================================

// Module: spike_rate_decoder
// PURPOSE
//  Receive-side counterpart of the LIF neuron spike output: turns the 1-bit spike train back into a rate value.
//  Counts spikes over fixed windows of enabled cycles and latches each window count into a result register.
//  Presents each result on a valid/ready handshake to downstream logic (display, next layer, host).
// PARAMETERS
//  WIDTH   8   result/counter width; counts saturate at 2^WIDTH-1
//  WINDOW  16  window length in enabled (en=1) cycles; legal 2..2^16-1
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  reset      in   1      synchronous, active-low (reset==0 clears state on posedge clk)
//  en         in   1      window advance enable; en=0 freezes window counter and ignores spikes
//  spike      in   1      spike input from neuron, one spike per cycle max
//  out_valid  out  1      result available
//  out_ready  in   1      downstream accepts result
//  rate       out  WIDTH  spike count of last completed window
//  saturated  out  1      set with out_valid when window count hit 2^WIDTH-1 (clamped)
//  overrun    out  1      sticky: a window completed while unread result pending
//  busy       out  1      1 in COUNT state
// BEHAVIOUR
//  Reset: out_valid=0, rate=0, saturated=0, overrun=0, busy=0, state=IDLE, counters=0.
//  FSM: IDLE -(en)-> COUNT; COUNT -(!en)-> PAUSE; PAUSE -(en)-> COUNT. No other transitions.
//   IDLE/PAUSE: window counter and spike counter hold; spikes dropped.
//  COUNT, per cycle with en=1: win_cnt increments; spk_cnt += spike (saturating at 2^WIDTH-1).
//  Window end = COUNT && en && win_cnt==WINDOW-1; spike on this cycle IS counted.
//   On window end: win_cnt<=0, spk_cnt<=0, result = spk_cnt+spike (saturated) -> rate next cycle.
//   Latency: rate/out_valid update 1 cycle after window-end cycle.
//  Handshake: transfer when out_valid&&out_ready; out_valid drops next cycle unless reloaded.
//   rate, saturated stable while out_valid=1 and no transfer.
//  Simultaneous window end + transfer: new result loaded, out_valid stays 1, no overrun.
//  Window end with out_valid=1 and no transfer: new result DROPPED, old rate kept, overrun<=1.
//   overrun cleared only by reset.
//  en falling on the window-end cycle: window still completes; FSM then enters PAUSE.
//  reset mid-window: partial count discarded, pending result lost, FSM to IDLE.
//  out_ready ignored when out_valid=0.
// CONFIGURATION
//  Macro SPIKE_DECODER_ISI_EN:
//   defined: extra port  isi  out  WIDTH  = cycles between the last two spikes (en=1 cycles only),
//    saturating at 2^WIDTH-1; updated the cycle after each spike after the first; reset value 0;
//    isi counter persists across window boundaries, frozen in PAUSE, cleared by reset.
//   undefined: no isi port, no ISI logic; all other behaviour identical.
// TESTING (WIDTH=8, WINDOW=16)
//  1. reset=0 for 2 cycles then 1, en=0 -> all outputs 0, state IDLE, busy=0.
//  2. en=1, spike=1 every 4th cycle, out_ready=1 -> out_valid 1 cycle after cycle 16, rate=4, saturated=0.
//  3. spike=1 every cycle, WIDTH=4 build -> rate=15, saturated=1 at window end.
//  4. out_ready=0 through two windows -> first rate held, overrun=1 after 2nd window end; raise out_ready -> out_valid drops.
//  5. en low for 5 cycles mid-window (spikes ignored) -> window spans 16 en=1 cycles; rate counts only those spikes.
//  6. reset=0 at win_cnt=8 with 3 spikes seen -> no result; next full window with 2 spikes gives rate=2.
//  7. SPIKE_DECODER_ISI_EN: spikes at en-cycles 3 and 10 -> isi=7; 300-cycle gap -> isi=255.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes over fixed windows of enabled cycles
// and offers each window count on a valid/ready handshake.
// Optional feature macro SPIKE_DECODER_ISI_EN adds an inter-spike-interval
// output (isi) measured in counting cycles.
module spike_rate_decoder #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             spike,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rate,
    output logic             saturated,
    output logic             overrun,
`ifdef SPIKE_DECODER_ISI_EN
    output logic [WIDTH-1:0] isi,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [15:0]      WIN_LAST = 16'(WINDOW - 1);

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_add1(input logic [WIDTH-1:0] v, input logic inc);
        if (inc && (v != CNT_MAX)) begin
            return v + WIDTH'(1'b1);
        end else begin
            return v;
        end
    endfunction

    state_t           state_r;
    logic [15:0]      win_cnt_r;
    logic [WIDTH-1:0] spk_cnt_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] rate_r;
    logic             saturated_r;
    logic             overrun_r;
    logic             busy_r;

    logic             cnt_en_s;
    logic             win_end_s;
    logic [WIDTH-1:0] result_s;
    logic             transfer_s;
    logic             load_s;

    // Per-cycle decode: counting qualifier, window end and handshake events.
    always_comb begin
        cnt_en_s   = (state_r == ST_COUNT) && en;
        win_end_s  = cnt_en_s && (win_cnt_r == WIN_LAST);
        result_s   = sat_add1(spk_cnt_r, spike);
        transfer_s = out_valid_r && out_ready;
        load_s     = win_end_s && (!out_valid_r || transfer_s);
    end

    // Control FSM; busy is registered alongside the state it reflects.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= en ? ST_COUNT : ST_IDLE;
                    busy_r  <= en;
                end
                ST_COUNT: begin
                    state_r <= en ? ST_COUNT : ST_PAUSE;
                    busy_r  <= en;
                end
                ST_PAUSE: begin
                    state_r <= en ? ST_COUNT : ST_PAUSE;
                    busy_r  <= en;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Window and spike counters; both restart at each window end.
    always_ff @(posedge clk) begin
        if (!reset) begin
            win_cnt_r <= 16'd0;
            spk_cnt_r <= '0;
        end else if (win_end_s) begin
            win_cnt_r <= 16'd0;
            spk_cnt_r <= '0;
        end else if (cnt_en_s) begin
            win_cnt_r <= win_cnt_r + 16'd1;
            spk_cnt_r <= result_s;
        end else begin
            win_cnt_r <= win_cnt_r;
            spk_cnt_r <= spk_cnt_r;
        end
    end

    // Result register and handshake; an unread result is never overwritten.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            rate_r      <= '0;
            saturated_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            rate_r      <= result_s;
            saturated_r <= (result_s == CNT_MAX);
        end else if (win_end_s) begin
            overrun_r   <= 1'b1;
        end else if (transfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

`ifdef SPIKE_DECODER_ISI_EN
    logic [WIDTH-1:0] gap_r;
    logic             seen_r;
    logic [WIDTH-1:0] isi_r;

    // Inter-spike interval: gap counts counting cycles since the last spike.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gap_r  <= '0;
            seen_r <= 1'b0;
            isi_r  <= '0;
        end else if (cnt_en_s && spike) begin
            gap_r  <= '0;
            seen_r <= 1'b1;
            isi_r  <= seen_r ? sat_add1(gap_r, 1'b1) : isi_r;
        end else if (cnt_en_s) begin
            gap_r  <= sat_add1(gap_r, 1'b1);
        end else begin
            gap_r  <= gap_r;
        end
    end

    assign isi = isi_r;
`endif

    assign out_valid = out_valid_r;
    assign rate      = rate_r;
    assign saturated = saturated_r;
    assign overrun   = overrun_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: a WIDTH=8 and a WIDTH=4
// instance share stimulus and are compared every cycle against a
// window/handshake reference model, plus directed literal expectations.
module tb_spike_rate_decoder;
    localparam int WINDOW = 16;

    logic clk = 1'b0;
    logic reset, en, spike, out_ready;
    logic va, sa, oa, ba;
    logic [7:0] ra;
    logic vb, sb, ob, bb;
    logic [3:0] rb;
`ifdef SPIKE_DECODER_ISI_EN
    logic [7:0] ia;
    logic [3:0] ib;
`endif

    always #5 clk = ~clk;

    spike_rate_decoder #(.WIDTH(8), .WINDOW(WINDOW)) dut_a (
        .clk(clk), .reset(reset), .en(en), .spike(spike),
        .out_valid(va), .out_ready(out_ready), .rate(ra), .saturated(sa),
        .overrun(oa),
`ifdef SPIKE_DECODER_ISI_EN
        .isi(ia),
`endif
        .busy(ba));

    spike_rate_decoder #(.WIDTH(4), .WINDOW(WINDOW)) dut_b (
        .clk(clk), .reset(reset), .en(en), .spike(spike),
        .out_valid(vb), .out_ready(out_ready), .rate(rb), .saturated(sb),
        .overrun(ob),
`ifdef SPIKE_DECODER_ISI_EN
        .isi(ib),
`endif
        .busy(bb));

    int checks = 0;
    int failures = 0;
    bit cmp_on = 1'b0;

    // Reference model: index 0 is the WIDTH=8 instance, index 1 the WIDTH=4 one.
    int m_max[2] = '{255, 15};
    int m_win[2], m_raw[2], m_rate[2], m_isi[2];
    bit m_valid[2], m_sat[2], m_ovr[2];
    bit prev_en;
    int cidx, last_spk;
    bit seen;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // A cycle counts only when en was also high on the previous cycle since reset.
    task automatic model_step();
        bit counting, xfer, wend;
        int res, d;
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_win[k] = 0; m_raw[k] = 0; m_rate[k] = 0; m_isi[k] = 0;
                m_valid[k] = 1'b0; m_sat[k] = 1'b0; m_ovr[k] = 1'b0;
            end
            prev_en = 1'b0; cidx = 0; last_spk = 0; seen = 1'b0;
        end else begin
            counting = en && prev_en;
            if (counting) begin
                cidx++;
                if (spike) begin
                    if (seen) begin
                        d = cidx - last_spk;
                        for (int k = 0; k < 2; k++) m_isi[k] = (d > m_max[k]) ? m_max[k] : d;
                    end
                    seen = 1'b1;
                    last_spk = cidx;
                end
            end
            for (int k = 0; k < 2; k++) begin
                xfer = m_valid[k] && out_ready;
                wend = 1'b0;
                res = 0;
                if (counting) begin
                    m_raw[k] += int'(spike);
                    m_win[k]++;
                    if (m_win[k] == WINDOW) begin
                        wend = 1'b1;
                        res = (m_raw[k] > m_max[k]) ? m_max[k] : m_raw[k];
                        m_win[k] = 0;
                        m_raw[k] = 0;
                    end
                end
                if (wend && (!m_valid[k] || xfer)) begin
                    m_rate[k] = res;
                    m_sat[k] = (res == m_max[k]);
                    m_valid[k] = 1'b1;
                end else if (wend) begin
                    m_ovr[k] = 1'b1;
                end else if (xfer) begin
                    m_valid[k] = 1'b0;
                end
            end
            prev_en = en;
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("valid_a", va, m_valid[0]);
            chk("rate_a", ra, m_rate[0]);
            chk("sat_a", sa, m_sat[0]);
            chk("ovr_a", oa, m_ovr[0]);
            chk("busy_a", ba, prev_en);
            chk("valid_b", vb, m_valid[1]);
            chk("rate_b", rb, m_rate[1]);
            chk("sat_b", sb, m_sat[1]);
            chk("ovr_b", ob, m_ovr[1]);
            chk("busy_b", bb, prev_en);
`ifdef SPIKE_DECODER_ISI_EN
            chk("isi_a", ia, m_isi[0]);
            chk("isi_b", ib, m_isi[1]);
`endif
        end
    end

    task automatic step(bit r, bit e, bit s, bit rd);
        reset = r; en = e; spike = s; out_ready = rd;
        @(posedge clk);
        #1;
        model_step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        bit got;

        // Reset for two cycles, then idle with en low.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        cmp_on = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_valid", va, 0);
        chk("rst_rate", ra, 0);
        chk("rst_ovr", oa, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle_busy", ba, 0);
        chk("idle_valid", va, 0);

        // Spike every 4th counting cycle, downstream always ready.
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, (i % 4) == 1, 1'b1);
            if (va && !got) begin
                got = 1'b1;
                chk("quarter_rate_a", ra, 4);
                chk("quarter_sat_a", sa, 0);
                chk("quarter_rate_b", rb, 4);
                chk("quarter_latency", i, 16);
            end
        end
        chk("quarter_seen", got, 1);

        // Spike every cycle: narrow instance clamps.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            if (vb && !got) begin
                got = 1'b1;
                chk("full_rate_b", rb, 15);
                chk("full_sat_b", sb, 1);
                chk("full_rate_a", ra, 16);
                chk("full_sat_a", sa, 0);
            end
        end
        chk("full_seen", got, 1);

        // Downstream stalls through two windows.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, (i % 2) == 0, 1'b0);
            if (i == 20) chk("stall_ovr_early", oa, 0);
        end
        chk("stall_valid", va, 1);
        chk("stall_rate", ra, 8);
        chk("stall_ovr", oa, 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("stall_drain_valid", va, 0);
        chk("stall_ovr_sticky", oa, 1);

        // Reset mid-window discards the partial count.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, (i == 2) || (i == 4) || (i == 6), 1'b1);
        chk("partial_no_result", va, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 1'b1, (i == 3) || (i == 9), 1'b1);
            if (va && !got) begin
                got = 1'b1;
                chk("after_reset_rate", ra, 2);
            end
        end
        chk("after_reset_seen", got, 1);

`ifdef SPIKE_DECODER_ISI_EN
        // Inter-spike intervals: 7 counting cycles, then a saturating gap.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int c = 1; c <= 12; c++) step(1'b1, 1'b1, (c == 3) || (c == 10), 1'b1);
        chk("isi_7", ia, 7);
        for (int c = 0; c < 300; c++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("isi_sat_a", ia, 255);
        chk("isi_sat_b", ib, 15);
`endif

        // Randomized traffic with pauses, stalls and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1);
        end

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
